claw_drop_sequencer: RTL and testbench
======================================

Name: claw_drop_sequencer

Overview:
Vertical-axis controller for the claw machine. It debounces the player's drop button and lowers the claw on a second 4-phase stepper. It then closes the grabber, dwells, and raises the claw back home. It feeds the horizontal gantry mover directly: it holds claw_dropped low for the whole drop cycle, then pulses claw_up once the claw is home.

Parameters:
STEP_DIV, 1_000_000, clock cycles per motor step (10 ms at 100 MHz)
DROP_STEPS, 2048, full steps from home to bottom
GRAB_CYCLES, 100_000_000, grabber dwell at bottom (1 s)
DEBOUNCE_CYCLES, 1_000_000, stable cycles required on drop button

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  reset, asynchronous, active-low
game_active  in  1  high while a game is running (upstream game FSM)
drop_btn  in  1  raw drop pushbutton, active-high, asynchronous
claw_dropped  out  1  active-low; low from drop acceptance through claw_up
claw_up  out  1  one-cycle pulse when claw returns home
grab  out  1  grabber/electromagnet enable
jc1, jc2, jc3, jc4  out  1 each  vertical stepper coil drives
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (CPU_RESETN low, asynchronous):
  - state=IDLE; phase=0; step_cnt=0; timers=0; drop_used=0.
  - Outputs: claw_dropped=1, claw_up=0, grab=0, jc1..jc4=0, busy=0.
- Button path:
  - drop_btn passes through a 2-FF synchroniser.
  - The debouncer updates its output only after the input has been stable for DEBOUNCE_CYCLES.
  - press = one-cycle rising edge of the debounced level.
- FSM; all outputs are registered:
  - IDLE: coils 0. If press && game_active && !drop_used, go to LOWER and set drop_used=1. Otherwise, including a press when game_active=0, ignore the press.
  - LOWER: claw_dropped=0.
    - A step tick fires every STEP_DIV cycles. The divider clears on state entry, so the first tick is STEP_DIV cycles after entry.
    - Each tick: phase=phase+1 mod 4, step_cnt+1.
    - On the tick where step_cnt reaches DROP_STEPS, go to GRAB.
  - GRAB: grab=1; coils hold the current phase. After GRAB_CYCLES cycles, go to RAISE.
  - RAISE: grab stays 1.
    - Each tick: phase=phase-1 mod 4, step_cnt-1.
    - On the tick where step_cnt reaches 0, go to DONE.
  - DONE: exactly one cycle. claw_up=1, claw_dropped=0, coils 0. Then go to IDLE, where claw_dropped returns to 1 and claw_up to 0.
- Coil table (phase -> jc1..jc4): 0 = 1001, 1 = 1010, 2 = 0110, 3 = 0101. Coils are driven in LOWER, GRAB and RAISE only.
- grab release: grab stays 1 after DONE. It clears in the first cycle game_active is 0 while in IDLE or DONE.
- drop_used clears whenever game_active is 0 and state is IDLE, giving one drop per game.
- game_active falling mid-sequence: the sequence still completes (LOWER, GRAB, RAISE, DONE) so the claw always returns home.
- Presses in any non-IDLE state are ignored and are not queued.
- Widths:
  - step_cnt: $clog2(DROP_STEPS+1) bits.
  - Step divider: $clog2(STEP_DIV) bits.
  - Dwell timer: $clog2(GRAB_CYCLES) bits.
  - Counters never wrap past their terminal values.
- Net home position: phase returns to its pre-drop value because the up and down step counts are equal.

Decomposition:
- Shared package claw_pkg:
  - Vertical-FSM state localparams IDLE, LOWER, GRAB, RAISE, DONE.
  - 4-entry full-step coil table.
  - Default STEP_DIV constant.
  - The gantry mover uses the same coil table.
- One sub-module: button_debouncer (parameter DEBOUNCE_CYCLES). It contains the synchroniser, stability counter and rising-edge pulse, and is reusable for the forwards/backwards joystick inputs.

Test Plan:
All scenarios use STEP_DIV=4, DROP_STEPS=8, GRAB_CYCLES=10, DEBOUNCE_CYCLES=3.
1. Full cycle:
   - Stimulus: game_active=1, drop_btn held high.
   - claw_dropped falls about 6 cycles later (2-FF sync, 3 stable, edge).
   - LOWER lasts 32 cycles with phases 1,2,3,0 repeating, 8 ticks.
   - GRAB lasts 10 cycles with grab=1.
   - RAISE lasts 32 cycles with phases descending.
   - claw_up is high for exactly 1 cycle, then claw_dropped=1 and coils 0000.
2. Bounce rejection: drop_btn toggles every 2 cycles for 40 cycles -> no transition; claw_dropped stays 1.
3. No game: press with game_active=0 -> state stays IDLE, busy=0. A second press within the same game after a completed drop is also ignored.
4. Mid-sequence abort: game_active drops during LOWER step 4 -> sequence completes; claw_up pulses; grab clears the following cycle; drop_used clears.
5. Reset mid-operation: CPU_RESETN low during RAISE -> all outputs take reset values immediately (asynchronous, no clock edge needed); after release, the block is IDLE with phase 0.
6. Press during busy: press in GRAB -> ignored; exactly one claw_up pulse for the whole sequence.

Source files
------------

// File: rtl/claw_pkg.sv
// claw_pkg: shared definitions for the claw machine motion controllers
package claw_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOWER = 3'd1,
        GRAB  = 3'd2,
        RAISE = 3'd3,
        DONE  = 3'd4
    } vstate_e;

    // Full-step coil patterns {jc1,jc2,jc3,jc4}, entry 0 in the low nibble
    localparam logic [3:0][3:0] COIL_TABLE = {4'b0101, 4'b0110, 4'b1010, 4'b1001};

    localparam int STEP_DIV_DEFAULT = 1_000_000;

    function automatic logic [3:0] coil_bits(input logic [1:0] phase);
        return COIL_TABLE[phase];
    endfunction

endpackage

// File: rtl/claw_drop_sequencer_debouncer.sv
// button_debouncer: synchronise a raw button, filter bounce, pulse once per debounced rise
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic btn,
    output logic press
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          settle;

    assign settle = (sync[1] != level) && (cnt == CNT_LAST);

    // Level follows the synchronised input only after it has differed for DEBOUNCE_CYCLES in a row
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            cnt   <= (sync[1] == level || settle) ? '0 : cnt + 1'b1;
            level <= settle ? sync[1] : level;
            press <= settle && sync[1];
        end
    end

endmodule

// File: rtl/claw_drop_sequencer.sv
// claw_drop_sequencer: vertical axis drop, grab, dwell and raise controller
module claw_drop_sequencer
    import claw_pkg::*;
#(
    parameter int STEP_DIV        = STEP_DIV_DEFAULT,
    parameter int DROP_STEPS      = 2048,
    parameter int GRAB_CYCLES     = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic game_active,
    input  logic drop_btn,
    output logic claw_dropped,
    output logic claw_up,
    output logic grab,
    output logic jc1,
    output logic jc2,
    output logic jc3,
    output logic jc4,
    output logic busy
);
    localparam int SW = $clog2(DROP_STEPS + 1);
    localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam int TW = GRAB_CYCLES > 1 ? $clog2(GRAB_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(STEP_DIV - 1);
    localparam logic [TW-1:0] GRAB_LAST  = TW'(GRAB_CYCLES - 1);
    localparam logic [SW-1:0] DOWN_LAST  = SW'(DROP_STEPS - 1);
    localparam logic [SW-1:0] UP_LAST    = SW'(1);

    vstate_e       state, state_n;
    logic [1:0]    phase, phase_n;
    logic [SW-1:0] step_cnt, step_n;
    logic [DW-1:0] div, div_n;
    logic [TW-1:0] timer, timer_n;
    logic          drop_used, used_n;
    logic          grab_n;
    logic          press;
    logic          tick;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_drop_debounce (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
        .btn       (drop_btn),
        .press     (press)
    );

    assign tick = (div == DIV_LAST);

    // Next state, step position, timers and one-drop-per-game bookkeeping
    always_comb begin
        state_n = state;
        phase_n = phase;
        step_n  = step_cnt;
        div_n   = div;
        timer_n = timer;
        used_n  = drop_used;
        grab_n  = grab;
        case (state)
            IDLE: begin
                if (!game_active) begin
                    used_n = 1'b0;
                    grab_n = 1'b0;
                end else if (press && !drop_used) begin
                    state_n = LOWER;
                    used_n  = 1'b1;
                    div_n   = '0;
                end
            end
            LOWER: begin
                div_n = tick ? '0 : div + 1'b1;
                if (tick) begin
                    phase_n = phase + 2'd1;
                    step_n  = step_cnt + 1'b1;
                    if (step_cnt == DOWN_LAST) begin
                        state_n = GRAB;
                        timer_n = '0;
                        grab_n  = 1'b1;
                    end
                end
            end
            GRAB: begin
                timer_n = (timer == GRAB_LAST) ? '0 : timer + 1'b1;
                if (timer == GRAB_LAST) begin
                    state_n = RAISE;
                    div_n   = '0;
                end
            end
            RAISE: begin
                div_n = tick ? '0 : div + 1'b1;
                if (tick) begin
                    phase_n = phase - 2'd1;
                    step_n  = step_cnt - 1'b1;
                    state_n = (step_cnt == UP_LAST) ? DONE : RAISE;
                end
            end
            DONE: begin
                state_n = IDLE;
                grab_n  = game_active ? grab : 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // State registers, with outputs registered from the next-state values so they align with state
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state               <= IDLE;
            phase               <= 2'd0;
            step_cnt            <= '0;
            div                 <= '0;
            timer               <= '0;
            drop_used           <= 1'b0;
            grab                <= 1'b0;
            claw_dropped        <= 1'b1;
            claw_up             <= 1'b0;
            busy                <= 1'b0;
            {jc1, jc2, jc3, jc4} <= 4'b0000;
        end else begin
            state               <= state_n;
            phase               <= phase_n;
            step_cnt            <= step_n;
            div                 <= div_n;
            timer               <= timer_n;
            drop_used           <= used_n;
            grab                <= grab_n;
            claw_dropped        <= (state_n == IDLE);
            claw_up             <= (state_n == DONE);
            busy                <= (state_n != IDLE);
            {jc1, jc2, jc3, jc4} <= (state_n inside {LOWER, GRAB, RAISE}) ? coil_bits(phase_n) : 4'b0000;
        end
    end

endmodule

// File: tb/tb_claw_drop_sequencer.sv
// tb_claw_drop_sequencer: randomized scenario bench with a cycle-indexed reference model
module tb_claw_drop_sequencer;
    localparam int SD = 4;
    localparam int DS = 8;
    localparam int GC = 10;
    localparam int DB = 3;
    localparam int LOWER_LEN = SD * DS;
    localparam int RAISE_END = 2 * SD * DS + GC;
    localparam int NEVER = 1_000_000;
    localparam logic [7:0] IDLE_VEC = 8'b1000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic game_active = 1'b0;
    logic drop_btn = 1'b0;
    logic claw_dropped, claw_up, grab, jc1, jc2, jc3, jc4, busy;
    logic [3:0] coil_ref [4] = '{4'b1001, 4'b1010, 4'b0110, 4'b0101};
    int tests = 0;
    int fails = 0;

    claw_drop_sequencer #(
        .STEP_DIV(SD), .DROP_STEPS(DS), .GRAB_CYCLES(GC), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .game_active(game_active), .drop_btn(drop_btn),
        .claw_dropped(claw_dropped), .claw_up(claw_up), .grab(grab),
        .jc1(jc1), .jc2(jc2), .jc3(jc3), .jc4(jc4), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Expected {claw_dropped, claw_up, grab, jc1..jc4, busy} k cycles after the drop is accepted
    function automatic logic [7:0] model(input int k, input int ga_off);
        int t;
        if (k < LOWER_LEN) return {3'b000, coil_ref[(k / SD) % 4], 1'b1};
        if (k < LOWER_LEN + GC) return {3'b001, coil_ref[DS % 4], 1'b1};
        if (k < RAISE_END) begin
            t = (k - LOWER_LEN - GC) / SD;
            return {3'b001, coil_ref[((DS - t) % 4 + 4) % 4], 1'b1};
        end
        if (k == RAISE_END) return 8'b0110_0001;
        return {2'b10, ga_off >= k, 5'b00000};
    endfunction

    function automatic logic [7:0] outs();
        return {claw_dropped, claw_up, grab, jc1, jc2, jc3, jc4, busy};
    endfunction

    task automatic run_drop(input string name, input int ga_off, input int rel_at,
                            input int press_at, input int stop_at, output int ups);
        int lat;
        logic [7:0] exp, obs;
        ups = 0;
        lat = 0;
        drop_btn = 1'b1;
        do begin
            @(negedge clk);
            lat++;
        end while (claw_dropped && lat < 12);
        tests++;
        if (claw_dropped !== 1'b0 || lat < 4 || lat > 10) begin
            fails++;
            $display("FAIL %s drop_latency: got %0d cycles claw_dropped=%b, need 4..10 cycles and 0", name, lat, claw_dropped);
            return;
        end
        for (int k = 0; k <= stop_at; k++) begin
            exp = model(k, ga_off);
            obs = outs();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s k=%0d outputs: got %b, need %b", name, k, obs, exp);
            end
            if (claw_up === 1'b1) ups++;
            if (k == stop_at) break;
            drop_btn = (k < rel_at) || (k >= press_at && k < press_at + 8);
            if (k >= ga_off) game_active = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic end_game();
        drop_btn = 1'b0;
        game_active = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (outs() !== IDLE_VEC) begin
            fails++;
            $display("FAIL end_game idle: got %b, need %b", outs(), IDLE_VEC);
        end
    endtask

    task automatic idle_watch(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tests++;
            if (claw_dropped !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL %s cycle %0d: got claw_dropped=%b busy=%b, need 1 0", name, i, claw_dropped, busy);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (outs() !== IDLE_VEC) begin
            fails++;
            $display("FAIL reset_async: got %b, need %b", outs(), IDLE_VEC);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (outs() !== IDLE_VEC) begin
            fails++;
            $display("FAIL reset_release: got %b, need %b", outs(), IDLE_VEC);
        end
    endtask

    task automatic test_full_cycle();
        int ups;
        game_active = 1'b1;
        run_drop("full_cycle", NEVER, NEVER, NEVER, RAISE_END + 6, ups);
        tests++;
        if (ups != 1) begin
            fails++;
            $display("FAIL full_cycle claw_up_count: got %0d, need 1", ups);
        end
        end_game();
    endtask

    task automatic test_bounce();
        int per;
        game_active = 1'b1;
        per = $urandom_range(1, 2);
        for (int i = 0; i < 40; i++) begin
            if (i % per == 0) drop_btn = ~drop_btn;
            @(negedge clk);
            tests++;
            if (claw_dropped !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL bounce cycle %0d: got claw_dropped=%b busy=%b, need 1 0", i, claw_dropped, busy);
            end
        end
        drop_btn = 1'b0;
        idle_watch("bounce_tail", 8);
        end_game();
    endtask

    task automatic test_no_game();
        int ups;
        game_active = 1'b0;
        drop_btn = 1'b1;
        idle_watch("no_game_press", $urandom_range(10, 16));
        drop_btn = 1'b0;
        idle_watch("no_game_release", 8);
        game_active = 1'b1;
        run_drop("first_drop", NEVER, NEVER, NEVER, RAISE_END + 3, ups);
        drop_btn = 1'b0;
        idle_watch("second_release", 8);
        drop_btn = 1'b1;
        idle_watch("second_press", 16);
        end_game();
    endtask

    task automatic test_abort();
        int ga_off, ups;
        for (int i = 0; i < 3; i++) begin
            ga_off = (i == 0) ? $urandom_range(3 * SD, 4 * SD - 1) : $urandom_range(0, RAISE_END);
            game_active = 1'b1;
            run_drop("abort", ga_off, NEVER, NEVER, RAISE_END + 6, ups);
            tests++;
            if (ups != 1) begin
                fails++;
                $display("FAIL abort claw_up_count: got %0d, need 1", ups);
            end
            end_game();
        end
        game_active = 1'b1;
        run_drop("after_abort", NEVER, NEVER, NEVER, RAISE_END + 3, ups);
        end_game();
    endtask

    task automatic test_reset_mid();
        int ups, r;
        game_active = 1'b1;
        r = $urandom_range(LOWER_LEN + GC + SD, RAISE_END - 1);
        run_drop("pre_reset", NEVER, NEVER, NEVER, r, ups);
        #2 rst_n = 1'b0;
        drop_btn = 1'b0;
        game_active = 1'b0;
        #1;
        tests++;
        if (outs() !== IDLE_VEC) begin
            fails++;
            $display("FAIL reset_mid_async: got %b, need %b", outs(), IDLE_VEC);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_watch("post_reset", 8);
        game_active = 1'b1;
        run_drop("after_reset", NEVER, NEVER, NEVER, RAISE_END + 3, ups);
        end_game();
    endtask

    task automatic test_press_busy();
        int ups;
        game_active = 1'b1;
        run_drop("press_busy", NEVER, 2, $urandom_range(LOWER_LEN - 4, LOWER_LEN + GC - 6), RAISE_END + 10, ups);
        tests++;
        if (ups != 1) begin
            fails++;
            $display("FAIL press_busy claw_up_count: got %0d, need 1", ups);
        end
        end_game();
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_bounce();
        test_no_game();
        test_abort();
        test_reset_mid();
        test_press_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
